// File: rtl/cfg_if.sv
// Config-port bus between the bus block and cfg_ctrl: the write strobe and data byte in,
// the decoded device selects back out.
interface cfg_if;
    logic       wr_port;
    logic [7:0] din;
    logic       ym_sel;
    logic       ym_stat;
    logic       saa_sel;

    modport master (output wr_port, din, input  ym_sel, ym_stat, saa_sel);
    modport slave  (input  wr_port, din, output ym_sel, ym_stat, saa_sel);
endinterface

// File: rtl/cfg_ctrl.sv
// Sound card config register, YM2203/SAA1099 clock generation from the 56MHz system clock,
// and the YM reset sequencer that runs after system reset.
module cfg_ctrl #(
    parameter int YM_DIV     = 16,
    parameter int SAA_DIV    = 7,
    parameter int RST_CYCLES = 1024
) (
    input  logic  clk,
    input  logic  rst,
    cfg_if.slave  bus,
    output logic  ym_half,
    output logic  ymclk,
    output logic  saaclk,
    output logic  ym_rst_n,
    output logic  busy
);
    localparam int RW = $clog2(RST_CYCLES);
    localparam int YW = $clog2(YM_DIV);
    localparam int SW = $clog2(SAA_DIV);

    typedef enum logic {HOLD, RUN} rst_state_t;

    rst_state_t    state, state_next;
    logic [RW-1:0] rcnt, rcnt_next;
    logic [YW-1:0] ycnt;
    logic [SW-1:0] scnt;
    logic          ph;
    logic          pending_half;
    logic          y_wrap;
    logic          s_wrap;
    logic          unused_din_hi;

    // The upper nibble is already qualified as 0xF by the bus block.
    assign unused_din_hi = ^bus.din[7:4];

    // ---------------- reset sequencer ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= HOLD;
            rcnt     <= '0;
            ym_rst_n <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_next;
            rcnt     <= rcnt_next;
            ym_rst_n <= (state_next == RUN);
            busy     <= (state_next == HOLD);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next = state;
        rcnt_next  = rcnt;
        case (state)
            HOLD: begin
                if (rcnt == RW'(RST_CYCLES - 1)) state_next = RUN;
                else                             rcnt_next  = rcnt + 1'b1;
            end
            RUN:     state_next = RUN;
            default: state_next = HOLD;
        endcase
    end

    // ---------------- config register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ym_sel   <= 1'b0;
            bus.ym_stat  <= 1'b0;
            bus.saa_sel  <= 1'b0;
            pending_half <= 1'b0;
        end else if (bus.wr_port && !busy) begin
            bus.ym_sel   <= ~bus.din[0];
            bus.ym_stat  <= ~bus.din[1];
            bus.saa_sel  <= ~bus.din[2];
            pending_half <= ~bus.din[3];
        end
    end

    // ---------------- SAA1099 clock ----------------
    assign s_wrap = (scnt == SW'(SAA_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt   <= '0;
            saaclk <= 1'b0;
        end else begin
            scnt   <= s_wrap ? '0 : scnt + 1'b1;
            saaclk <= (scnt < SW'(SAA_DIV / 2));
        end
    end

    // ---------------- YM2203 clock ----------------
    assign y_wrap = (ycnt == YW'(YM_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ycnt    <= '0;
            ph      <= 1'b0;
            ymclk   <= 1'b0;
            ym_half <= 1'b0;
        end else begin
            ycnt  <= y_wrap ? '0 : ycnt + 1'b1;
            ymclk <= ym_half ? ~ph : (ycnt < YW'(YM_DIV / 2));
            if (y_wrap) ph <= ~ph;
            // Wrapping into ph=0 is a rising boundary in both modes, so switching here never
            // shortens a phase.
            if (y_wrap && ph) ym_half <= pending_half;
        end
    end
endmodule

// File: tb/tb_cfg_ctrl.sv
// Self-checking bench for cfg_ctrl: an edge-count based reference model compared every cycle,
// phase-length monitors, and directed plus randomized config traffic.
module tb_cfg_ctrl;
    localparam int YM_DIV     = 16;
    localparam int SAA_DIV    = 7;
    localparam int RST_CYCLES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ym_half, ymclk, saaclk, ym_rst_n, busy;

    cfg_if bus ();

    cfg_ctrl #(.YM_DIV(YM_DIV), .SAA_DIV(SAA_DIV), .RST_CYCLES(RST_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ym_half  (ym_half),
        .ymclk    (ymclk),
        .saaclk   (saaclk),
        .ym_rst_n (ym_rst_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, int'(act === 1'b1), int'(exp === 1'b1));
    endtask

    // ---------------- reference model ----------------
    // Everything derives from m_t, the number of clock edges since the last reset edge:
    // the divider position is m_t mod YM_DIV, the YM phase is (m_t / YM_DIV) mod 2.
    int   m_t = 0;
    bit   model_valid = 0;
    logic m_sel, m_stat, m_saa, m_pend, m_half, m_ymclk, m_saaclk;

    always @(posedge clk) begin
        bit busy_before;
        if (rst) begin
            m_t = 0;
            {m_sel, m_stat, m_saa, m_pend, m_half, m_ymclk, m_saaclk} = '0;
            model_valid = 1;
        end else if (model_valid) begin
            busy_before = (m_t < RST_CYCLES);
            m_ymclk  = m_half ? (((m_t / YM_DIV) % 2) == 0) : ((m_t % YM_DIV) < YM_DIV / 2);
            m_saaclk = (m_t % SAA_DIV) < SAA_DIV / 2;
            if (((m_t + 1) % (2 * YM_DIV)) == 0) m_half = m_pend;
            if (bus.wr_port && !busy_before) begin
                m_sel  = ~bus.din[0];
                m_stat = ~bus.din[1];
                m_saa  = ~bus.din[2];
                m_pend = ~bus.din[3];
            end
            m_t++;
        end
    end

    // ---------------- per-cycle compare and phase monitors ----------------
    logic y_prev, s_prev;
    int   y_len, s_len;
    bit   y_ok, s_ok;

    always @(negedge clk) begin
        if (model_valid) begin
            chk1("ym_sel",   bus.ym_sel,  m_sel);
            chk1("ym_stat",  bus.ym_stat, m_stat);
            chk1("saa_sel",  bus.saa_sel, m_saa);
            chk1("ym_half",  ym_half,     m_half);
            chk1("ymclk",    ymclk,       m_ymclk);
            chk1("saaclk",   saaclk,      m_saaclk);
            chk1("ym_rst_n", ym_rst_n,    m_t >= RST_CYCLES);
            chk1("busy",     busy,        m_t <  RST_CYCLES);
            if (m_t == 0) begin
                y_prev = ymclk;  y_len = 1; y_ok = 0;
                s_prev = saaclk; s_len = 1; s_ok = 0;
            end else begin
                if (ymclk !== y_prev) begin
                    if (y_ok) check("ym_phase_len_8_or_16",
                                    int'(y_len == YM_DIV / 2 || y_len == YM_DIV), 1);
                    y_ok = 1; y_len = 1; y_prev = ymclk;
                end else y_len++;
                if (saaclk !== s_prev) begin
                    if (s_ok) check(s_prev ? "saa_high_len" : "saa_low_len", s_len,
                                    s_prev ? SAA_DIV / 2 : SAA_DIV - SAA_DIV / 2);
                    s_ok = 1; s_len = 1; s_prev = saaclk;
                end else s_len++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_byte(input logic [7:0] b);
        bus.wr_port = 1'b1;
        bus.din     = b;
        @(negedge clk);
        bus.wr_port = 1'b0;
    endtask

    task automatic count_busy(output int n, input bit inject);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            if (inject && n == 100) begin
                bus.wr_port = 1'b1;
                bus.din     = 8'hF7;
            end else bus.wr_port = 1'b0;
            n++;
            @(negedge clk);
        end
        bus.wr_port = 1'b0;
    endtask

    task automatic wait_half(input string name, input logic exp, input int budget);
        int k = 0;
        while (ym_half !== exp && k < budget) begin
            k++;
            @(negedge clk);
        end
        chk1(name, ym_half, exp);
    endtask

    task automatic wait_ypos(input int pos, input int modulus);
        int k = 0;
        while ((m_t % modulus) != pos && k < 2 * modulus) begin
            k++;
            @(negedge clk);
        end
        check("ypos_reached", m_t % modulus, pos);
    endtask

    initial begin
        int n;
        bus.wr_port = 1'b0;
        bus.din     = 8'hFF;

        // Reset then idle, with a dropped write during HOLD.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_busy(n, 1'b1);
        check("hold_len_after_rst", n, 1024);
        chk1("ym_rst_n_after_hold", ym_rst_n, 1'b1);
        chk1("hold_write_dropped_sel", bus.ym_sel, 1'b0);
        chk1("hold_write_dropped_pend", m_pend, 1'b0);
        repeat (40) @(negedge clk);
        chk1("ym_half_still_full", ym_half, 1'b0);

        // Select decoding.
        write_byte(8'hFE);
        chk1("fe_ym_sel",  bus.ym_sel,  1'b1);
        chk1("fe_ym_stat", bus.ym_stat, 1'b0);
        chk1("fe_saa_sel", bus.saa_sel, 1'b0);
        write_byte(8'hF9);
        chk1("f9_ym_sel",  bus.ym_sel,  1'b0);
        chk1("f9_ym_stat", bus.ym_stat, 1'b1);
        chk1("f9_saa_sel", bus.saa_sel, 1'b1);
        repeat (20) @(negedge clk);

        // Half-rate entry at divider position 3, then back to full rate mid half-period.
        wait_ypos(3, YM_DIV);
        write_byte(8'hF7);
        chk1("f7_model_pend", m_pend, 1'b1);
        wait_half("half_on", 1'b1, 4 * YM_DIV);
        repeat (70) @(negedge clk);
        wait_ypos(8, 2 * YM_DIV);
        write_byte(8'hFF);
        chk1("ff_half_holds_until_rise", ym_half, 1'b1);
        wait_half("half_off", 1'b0, 4 * YM_DIV);
        repeat (70) @(negedge clk);

        // Back-to-back strobes: the last one wins.
        bus.wr_port = 1'b1;
        bus.din     = 8'hFE;
        @(negedge clk);
        bus.din     = 8'hFB;
        @(negedge clk);
        bus.wr_port = 1'b0;
        chk1("b2b_ym_sel",  bus.ym_sel,  1'b0);
        chk1("b2b_saa_sel", bus.saa_sel, 1'b1);

        // One-clock reset pulse in RUN with ym_sel=1 and half rate applied.
        write_byte(8'hF6);
        wait_half("f6_half_on", 1'b1, 4 * YM_DIV);
        chk1("f6_ym_sel", bus.ym_sel, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rst_ym_sel",   bus.ym_sel,  1'b0);
        chk1("rst_ym_stat",  bus.ym_stat, 1'b0);
        chk1("rst_saa_sel",  bus.saa_sel, 1'b0);
        chk1("rst_ym_half",  ym_half,     1'b0);
        chk1("rst_ymclk",    ymclk,       1'b0);
        chk1("rst_saaclk",   saaclk,      1'b0);
        chk1("rst_ym_rst_n", ym_rst_n,    1'b0);
        chk1("rst_busy",     busy,        1'b1);
        count_busy(n, 1'b0);
        check("hold_len_after_pulse", n, 1024);

        // Randomized config traffic with rare resets.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 1999) == 0);
            bus.wr_port = ($urandom_range(0, 3) == 0);
            bus.din     = 8'hF0 | 8'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst         = 1'b0;
        bus.wr_port = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
